// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: line defaults kept in step with uart_tx, receiver
// state encoding and the bit-timer divider helper.
package uart_rx_pkg;

  localparam int c_def_clkfreq  = 100_000_000;
  localparam int c_def_baudrate = 10_000_000;
  localparam int c_def_stopbit  = 2;
  localparam int c_def_nbits    = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_WAITHI = 3'd4
  } rx_state_t;

  function automatic int bit_timer_lim(input int clkfreq, input int baudrate);
    return clkfreq / baudrate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs with a parameterised reset
// value, so idle-high lines come out of reset without a spurious edge.
module sync_2ff #(
  parameter int   c_width  = 1,
  parameter logic c_rstval = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_width-1:0] d,
  output logic [c_width-1:0] q
);

  logic [c_width-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {c_width{c_rstval}};
      q    <= {c_width{c_rstval}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, centre sampling via a bit timer, LSB-first
// data shift, first-stop-bit check with done/framing-error ticks.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int c_clkfreq  = c_def_clkfreq,
  parameter int c_baudrate = c_def_baudrate,
  parameter int c_stopbit  = c_def_stopbit,
  parameter int gonbitsys  = c_def_nbits
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [gonbitsys-1:0] dout_o,
  output logic                 rx_done_tick_o,
  output logic                 frame_err_o
);

  localparam int c_bittimerlim = bit_timer_lim(c_clkfreq, c_baudrate);
  localparam int c_tw = $clog2(c_bittimerlim);
  localparam int c_cw = $clog2(gonbitsys + 1);
  localparam logic [c_tw-1:0] c_tlast = c_tw'(c_bittimerlim - 1);
  localparam logic [c_tw-1:0] c_tmid  = c_tw'(c_bittimerlim / 2 - 1);
  localparam logic [c_cw-1:0] c_clast = c_cw'(gonbitsys - 1);

  // Centre sampling needs at least 4 clocks per bit; the frame needs a stop bit.
  if (c_bittimerlim < 4 || c_stopbit < 1) begin : g_cfg_check
    $error("uart_rx: unsupported configuration");
  end

  rx_state_t            state_q, state_d;
  logic [c_tw-1:0]      timer_q, timer_d;
  logic [c_cw-1:0]      bitcnt_q, bitcnt_d;
  logic [gonbitsys-1:0] shreg_q, shreg_d;
  logic [gonbitsys-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rx_s, rx_s_d;
  logic                 fall_edge;
  logic                 timer_wrap;

  sync_2ff #(.c_width(1), .c_rstval(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_i),
    .q     (rx_s)
  );

  assign fall_edge  = rx_s_d & ~rx_s;
  assign timer_wrap = (timer_q == c_tlast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s_d   <= 1'b1;
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rx_s_d   <= rx_s;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall_edge) state_d = S_START;
      end
      // A start bit that is high again at its centre was only a glitch.
      S_START: begin
        if (timer_q == c_tmid) state_d = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (timer_wrap) begin
          shreg_d = {rx_s, shreg_q[gonbitsys-1:1]};
          if (bitcnt_q == c_clast) begin
            bitcnt_d = '0;
            state_d  = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      // Leaving at mid stop bit leaves time to catch the next start edge.
      S_STOP: begin
        if (timer_wrap) begin
          if (rx_s) begin
            dout_d  = shreg_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_WAITHI;
          end
        end
      end
      S_WAITHI: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q || state_q == S_IDLE || timer_wrap) timer_d = '0;
    else timer_d = timer_q + 1'b1;
  end

  assign dout_o         = dout_q;
  assign rx_done_tick_o = done_q;
  assign frame_err_o    = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-driven serial frames at 10 and 4 clocks
// per bit, with tick monitors and per-scenario checks.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       rx_line4 = 1'b1;
  logic [9:0] dout, dout4;
  logic       done, err, done4, err4;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cyc = 0;

  int done_cnt = 0, err_cnt = 0, done4_cnt = 0, err4_cnt = 0;
  int overlap_cnt = 0, adjacent_cnt = 0, last_done_cyc = 0;
  logic prev_tick = 1'b0;
  logic [9:0] dout_log[$];
  logic [9:0] dout4_log[$];

  uart_rx #(
    .c_clkfreq(100_000_000), .c_baudrate(10_000_000), .c_stopbit(2), .gonbitsys(10)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_line),
    .dout_o(dout), .rx_done_tick_o(done), .frame_err_o(err)
  );

  uart_rx #(
    .c_clkfreq(100_000_000), .c_baudrate(25_000_000), .c_stopbit(2), .gonbitsys(10)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_line4),
    .dout_o(dout4), .rx_done_tick_o(done4), .frame_err_o(err4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      dout_log.push_back(dout);
      last_done_cyc <= cyc;
    end
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) overlap_cnt <= overlap_cnt + 1;
    if ((done || err) && prev_tick) adjacent_cnt <= adjacent_cnt + 1;
    prev_tick <= done || err;
    if (done4) begin
      done4_cnt <= done4_cnt + 1;
      dout4_log.push_back(dout4);
    end
    if (err4) err4_cnt <= err4_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel4, input logic val, input int lim);
    if (sel4) rx_line4 = val;
    else rx_line = val;
    wait_cycles(lim);
  endtask

  task automatic send_frame(input bit sel4, input logic [9:0] data, input logic stop_val,
                            input int lim);
    start_cyc = cyc;
    drive_bit(sel4, 1'b0, lim);
    for (int i = 0; i < 10; i++) drive_bit(sel4, data[i], lim);
    for (int i = 0; i < 2; i++) drive_bit(sel4, stop_val, lim);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (dout !== 10'h000) $display("[TB] FAIL reset_dout: got %h, expected %h", dout, 10'h000);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", done);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b, expected 0", err);
    else n_pass++;
    n_checks++;
    if (dout4 !== 10'h000) $display("[TB] FAIL reset_dout4: got %h, expected %h", dout4, 10'h000);
    else n_pass++;
    rst_n = 1'b1;
    wait_cycles(10);
  endtask

  task automatic test_single();
    int d0, e0, lat;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(1'b0, 10'b1100110011, 1'b1, 10);
    wait_cycles(20);
    n_checks++;
    if (done_cnt - d0 !== 1) $display("[TB] FAIL single_ticks: got %0d, expected 1", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (dout !== 10'h333) $display("[TB] FAIL single_dout: got %h, expected %h", dout, 10'h333);
    else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== 0) $display("[TB] FAIL single_err: got %0d, expected 0", err_cnt - e0);
    else n_pass++;
    lat = last_done_cyc - start_cyc - 1;
    n_checks++;
    if (lat < 116 || lat > 118) $display("[TB] FAIL single_latency: got %0d, expected 117 +/-1", lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0, e0, b;
    logic [9:0] w0, w1;
    d0 = done_cnt;
    e0 = err_cnt;
    b = dout_log.size();
    send_frame(1'b0, 10'b1100110011, 1'b1, 10);
    send_frame(1'b0, 10'b1110001110, 1'b1, 10);
    wait_cycles(20);
    w0 = (dout_log.size() > b) ? dout_log[b] : 10'hxxx;
    w1 = (dout_log.size() > b + 1) ? dout_log[b+1] : 10'hxxx;
    n_checks++;
    if (done_cnt - d0 !== 2) $display("[TB] FAIL b2b_ticks: got %0d, expected 2", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (w0 !== 10'h333) $display("[TB] FAIL b2b_word0: got %h, expected %h", w0, 10'h333);
    else n_pass++;
    n_checks++;
    if (w1 !== 10'h38E) $display("[TB] FAIL b2b_word1: got %h, expected %h", w1, 10'h38E);
    else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== 0) $display("[TB] FAIL b2b_err: got %0d, expected 0", err_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    rx_line = 1'b0;
    wait_cycles(3);
    rx_line = 1'b1;
    wait_cycles(200);
    n_checks++;
    if (done_cnt - d0 !== 0) $display("[TB] FAIL glitch_done: got %0d, expected 0", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (err_cnt - e0 !== 0) $display("[TB] FAIL glitch_err: got %0d, expected 0", err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (dout !== 10'h38E) $display("[TB] FAIL glitch_dout: got %h, expected %h", dout, 10'h38E);
    else n_pass++;
  endtask

  task automatic test_frame_error();
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(1'b0, 10'h2AA, 1'b0, 10);
    wait_cycles(5);
    n_checks++;
    if (err_cnt - e0 !== 1) $display("[TB] FAIL ferr_pulse: got %0d, expected 1", err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 0) $display("[TB] FAIL ferr_done: got %0d, expected 0", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (dout !== 10'h38E) $display("[TB] FAIL ferr_dout: got %h, expected %h", dout, 10'h38E);
    else n_pass++;
    wait_cycles(500);
    n_checks++;
    if ((err_cnt - e0 !== 1) || (done_cnt - d0 !== 0))
      $display("[TB] FAIL break_quiet: got err %0d done %0d, expected err 1 done 0",
               err_cnt - e0, done_cnt - d0);
    else n_pass++;
    rx_line = 1'b1;
    wait_cycles(20);
    send_frame(1'b0, 10'h155, 1'b1, 10);
    wait_cycles(20);
    n_checks++;
    if (done_cnt - d0 !== 1) $display("[TB] FAIL recover_done: got %0d, expected 1", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (dout !== 10'h155) $display("[TB] FAIL recover_dout: got %h, expected %h", dout, 10'h155);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int d0, e0;
    logic [9:0] data;
    data = 10'h3E0;
    d0 = done_cnt;
    e0 = err_cnt;
    drive_bit(1'b0, 1'b0, 10);
    for (int i = 0; i < 5; i++) drive_bit(1'b0, data[i], 10);
    rx_line = data[5];
    wait_cycles(3);
    rst_n = 1'b0;
    wait_cycles(1);
    n_checks++;
    if ({dout, done, err} !== 12'h000)
      $display("[TB] FAIL midreset_outputs: got dout %h done %b err %b, expected all 0",
               dout, done, err);
    else n_pass++;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(4);
    for (int i = 6; i < 10; i++) drive_bit(1'b0, data[i], 10);
    drive_bit(1'b0, 1'b1, 20);
    wait_cycles(30);
    n_checks++;
    if ((done_cnt - d0 !== 0) || (err_cnt - e0 !== 0))
      $display("[TB] FAIL midreset_ticks: got done %0d err %0d, expected 0 0",
               done_cnt - d0, err_cnt - e0);
    else n_pass++;
    n_checks++;
    if (dout !== 10'h000) $display("[TB] FAIL midreset_dout: got %h, expected %h", dout, 10'h000);
    else n_pass++;
    send_frame(1'b0, 10'h0F0, 1'b1, 10);
    wait_cycles(20);
    n_checks++;
    if (dout !== 10'h0F0) $display("[TB] FAIL after_reset_dout: got %h, expected %h", dout, 10'h0F0);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("[TB] FAIL after_reset_done: got %0d, expected 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_min_divider();
    int d0, e0, b;
    logic [9:0] w0, w1;
    d0 = done4_cnt;
    e0 = err4_cnt;
    b = dout4_log.size();
    send_frame(1'b1, 10'h3FF, 1'b1, 4);
    send_frame(1'b1, 10'h000, 1'b1, 4);
    wait_cycles(10);
    w0 = (dout4_log.size() > b) ? dout4_log[b] : 10'hxxx;
    w1 = (dout4_log.size() > b + 1) ? dout4_log[b+1] : 10'hxxx;
    n_checks++;
    if (done4_cnt - d0 !== 2) $display("[TB] FAIL div4_ticks: got %0d, expected 2", done4_cnt - d0);
    else n_pass++;
    n_checks++;
    if (w0 !== 10'h3FF) $display("[TB] FAIL div4_word0: got %h, expected %h", w0, 10'h3FF);
    else n_pass++;
    n_checks++;
    if (w1 !== 10'h000) $display("[TB] FAIL div4_word1: got %h, expected %h", w1, 10'h000);
    else n_pass++;
    n_checks++;
    if (err4_cnt - e0 !== 0) $display("[TB] FAIL div4_err: got %0d, expected 0", err4_cnt - e0);
    else n_pass++;
  endtask

  task automatic test_tick_rules();
    n_checks++;
    if (overlap_cnt !== 0) $display("[TB] FAIL tick_overlap: got %0d, expected 0", overlap_cnt);
    else n_pass++;
    n_checks++;
    if (adjacent_cnt !== 0) $display("[TB] FAIL tick_adjacent: got %0d, expected 0", adjacent_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_min_divider();
    test_tick_rules();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
